// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: fetch handshake, decode, EX/MDU timing,
// load/store handshake and writeback strobes, with handshake timeouts.
module ctrl_seq #(
   parameter bit EN_M    = 1'b1,
   parameter int MDU_LAT = 4,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_valid,
   input  logic        ifu_req_ready,
   input  logic        ifu_rsp_valid,
   input  logic [31:0] ifu_rsp_inst,
   output logic        lsu_req_valid,
   input  logic        lsu_req_ready,
   output logic        lsu_req_wen,
   output logic [2:0]  lsu_req_size,
   input  logic        lsu_rsp_valid,
   output logic [31:0] inst_o,
   output logic [4:0]  alu_op_o,
   output logic [1:0]  srca_sel_o,
   output logic [1:0]  srcb_sel_o,
   output logic [2:0]  imm_type_o,
   input  logic        br_taken_i,
   output logic [1:0]  pc_sel_o,
   output logic        rd_wen_o,
   output logic        pc_wen_o,
   output logic        halt_o,
   output logic [1:0]  err_o
);
   localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [2:0] S_IDLE = 3'd0, S_IF = 3'd1, S_IW = 3'd2, S_EX = 3'd3,
                          S_MR = 3'd4, S_MW = 3'd5, S_WB = 3'd6, S_HALT = 3'd7;

   logic [2:0]    state;
   logic [31:0]   inst_q;
   logic [4:0]    alu_q;
   logic [1:0]    sa_q, sb_q, psel_q, err_q;
   logic [2:0]    imm_q, size_q;
   logic          rdw_q, mem_q, wen_q, brk_q, br_q;
   logic [CW-1:0] ex_cnt;
   logic [TW-1:0] ifu_cnt, lsu_cnt;

   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic [4:0] d_alu;
   logic [1:0] d_sa, d_sb, d_psel;
   logic [2:0] d_imm;
   logic       d_legal, d_rdw, d_mem, d_wen, d_m, d_brk, d_br;
   logic       ifu_tmo, lsu_tmo;

   assign opc = ifu_rsp_inst[6:0];
   assign f3  = ifu_rsp_inst[14:12];
   assign f7  = ifu_rsp_inst[31:25];

   always_comb begin
      d_legal = 1'b0; d_alu = 5'd0; d_sa = 2'd0; d_sb = 2'd0; d_imm = 3'd0;
      d_psel = 2'd0;  d_rdw = 1'b0; d_mem = 1'b0; d_wen = 1'b0; d_m = 1'b0;
      d_brk = 1'b0;   d_br = 1'b0;
      case (opc)
         7'b0110111: begin d_legal = 1'b1; d_sa = 2'd2; d_sb = 2'd1; d_imm = 3'd3; d_rdw = 1'b1; end
         7'b0010111: begin d_legal = 1'b1; d_sa = 2'd1; d_sb = 2'd1; d_imm = 3'd3; d_rdw = 1'b1; end
         7'b1101111: begin
            d_legal = 1'b1; d_sa = 2'd1; d_sb = 2'd2; d_imm = 3'd4; d_psel = 2'd1; d_rdw = 1'b1;
         end
         7'b1100111: begin
            d_legal = (f3 == 3'd0); d_sa = 2'd1; d_sb = 2'd2; d_psel = 2'd2; d_rdw = 1'b1;
         end
         7'b1100011: begin
            d_legal = (f3 != 3'd2) && (f3 != 3'd3); d_alu = 5'b01000; d_imm = 3'd2; d_br = 1'b1;
         end
         7'b0000011: begin
            d_legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; d_sb = 2'd1; d_rdw = 1'b1; d_mem = 1'b1;
         end
         7'b0100011: begin
            d_legal = (f3 <= 3'd2); d_sb = 2'd1; d_imm = 3'd1; d_mem = 1'b1; d_wen = 1'b1;
         end
         7'b0010011: begin
            d_sb = 2'd1; d_rdw = 1'b1; d_alu = {2'b00, f3};
            if (f3 == 3'd1) begin
               d_legal = (f7 == 7'd0); d_imm = 3'd5;
            end else if (f3 == 3'd5) begin
               d_legal = (f7 == 7'd0) || (f7 == 7'b0100000); d_imm = 3'd5; d_alu = {1'b0, f7[5], f3};
            end else begin
               d_legal = 1'b1;
            end
         end
         7'b0110011: begin
            d_rdw = 1'b1;
            if (f7 == 7'd0) begin
               d_legal = 1'b1; d_alu = {2'b00, f3};
            end else if (f7 == 7'b0100000) begin
               d_legal = (f3 == 3'd0) || (f3 == 3'd5); d_alu = {2'b01, f3};
            end else if (f7 == 7'b0000001 && EN_M) begin
               d_legal = 1'b1; d_m = 1'b1; d_alu = {2'b10, f3};
            end
         end
         7'b0001111: d_legal = (f3 == 3'd0);  // fence: executes as a no-op
         7'b1110011: begin d_legal = (ifu_rsp_inst == 32'h0010_0073); d_brk = 1'b1; end
         default: ;
      endcase
   end

   assign ifu_tmo = (TIMEOUT != 0) && (ifu_cnt == TW'(TIMEOUT - 1));
   assign lsu_tmo = (TIMEOUT != 0) && (lsu_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE; inst_q <= '0; alu_q <= '0; sa_q <= '0; sb_q <= '0; psel_q <= '0;
         err_q <= '0; imm_q <= '0; size_q <= '0; rdw_q <= 1'b0; mem_q <= 1'b0; wen_q <= 1'b0;
         brk_q <= 1'b0; br_q <= 1'b0; ex_cnt <= '0; ifu_cnt <= '0; lsu_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin state <= S_IF; ifu_cnt <= '0; end
            S_IF: begin
               ifu_cnt <= ifu_cnt + 1'b1;
               if (ifu_req_ready) state <= S_IW;
               else if (ifu_tmo) begin state <= S_HALT; err_q <= 2'd2; end
            end
            S_IW: begin
               ifu_cnt <= ifu_cnt + 1'b1;
               if (ifu_rsp_valid) begin
                  inst_q <= ifu_rsp_inst; alu_q <= d_alu; sa_q <= d_sa; sb_q <= d_sb;
                  imm_q <= d_imm; psel_q <= d_psel; size_q <= f3; mem_q <= d_mem;
                  wen_q <= d_wen; brk_q <= d_brk; br_q <= d_br;
                  rdw_q <= d_rdw && (ifu_rsp_inst[11:7] != 5'd0);
                  ex_cnt <= d_m ? CW'(MDU_LAT - 1) : '0;
                  if (d_legal) state <= S_EX;
                  else begin state <= S_HALT; err_q <= 2'd1; end
               end else if (ifu_tmo) begin
                  state <= S_HALT; err_q <= 2'd2;
               end
            end
            S_EX: begin
               if (ex_cnt != '0) ex_cnt <= ex_cnt - 1'b1;
               else begin
                  // branch target choice is only known once the compare settles
                  if (br_q) psel_q <= br_taken_i ? 2'd1 : 2'd0;
                  if (mem_q) begin state <= S_MR; lsu_cnt <= '0; end
                  else if (brk_q) state <= S_HALT;
                  else state <= S_WB;
               end
            end
            S_MR: begin
               lsu_cnt <= lsu_cnt + 1'b1;
               if (lsu_req_ready) state <= S_MW;
               else if (lsu_tmo) begin state <= S_HALT; err_q <= 2'd3; end
            end
            S_MW: begin
               lsu_cnt <= lsu_cnt + 1'b1;
               if (lsu_rsp_valid) state <= S_WB;
               else if (lsu_tmo) begin state <= S_HALT; err_q <= 2'd3; end
            end
            S_WB: begin state <= S_IF; ifu_cnt <= '0; end
            default: ;
         endcase
      end
   end

   assign ifu_req_valid = (state == S_IF);
   assign lsu_req_valid = (state == S_MR);
   assign lsu_req_wen   = wen_q;
   assign lsu_req_size  = size_q;
   assign inst_o        = inst_q;
   assign alu_op_o      = alu_q;
   assign srca_sel_o    = sa_q;
   assign srcb_sel_o    = sb_q;
   assign imm_type_o    = imm_q;
   assign pc_sel_o      = psel_q;
   assign rd_wen_o      = (state == S_WB) && rdw_q;
   assign pc_wen_o      = (state == S_WB);
   assign halt_o        = (state == S_HALT);
   assign err_o         = err_q;
endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: random instruction stream on one instance,
// illegal-M, ebreak, timeouts and mid-transaction reset on a second.
module tb_ctrl_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  alu;
      logic [1:0]  sa, sb, ps;
      logic [2:0]  imm, sz;
      logic        rdw, mem, wen, ci;
      int          ex, lrdy;
   } exp_t;

   localparam int MLAT = 4;

   logic a_rst, a_ifv, a_ifr, a_irv, a_lv, a_lr, a_lw, a_lrv, a_br, a_rdw, a_pcw, a_halt;
   logic [31:0] a_rinst, a_inst;
   logic [2:0]  a_lsz, a_imm;
   logic [4:0]  a_alu;
   logic [1:0]  a_sa, a_sb, a_ps, a_err;
   logic b_rst, b_ifv, b_ifr, b_irv, b_lv, b_lr, b_lw, b_lrv, b_br, b_rdw, b_pcw, b_halt;
   logic [31:0] b_rinst, b_inst;
   logic [2:0]  b_lsz, b_imm;
   logic [4:0]  b_alu;
   logic [1:0]  b_sa, b_sb, b_ps, b_err;

   ctrl_seq #(.EN_M(1'b1), .MDU_LAT(MLAT), .TIMEOUT(40)) u_a (
      .clk(clk), .rst(a_rst), .ifu_req_valid(a_ifv), .ifu_req_ready(a_ifr),
      .ifu_rsp_valid(a_irv), .ifu_rsp_inst(a_rinst), .lsu_req_valid(a_lv),
      .lsu_req_ready(a_lr), .lsu_req_wen(a_lw), .lsu_req_size(a_lsz),
      .lsu_rsp_valid(a_lrv), .inst_o(a_inst), .alu_op_o(a_alu), .srca_sel_o(a_sa),
      .srcb_sel_o(a_sb), .imm_type_o(a_imm), .br_taken_i(a_br), .pc_sel_o(a_ps),
      .rd_wen_o(a_rdw), .pc_wen_o(a_pcw), .halt_o(a_halt), .err_o(a_err));

   ctrl_seq #(.EN_M(1'b0), .MDU_LAT(MLAT), .TIMEOUT(8)) u_b (
      .clk(clk), .rst(b_rst), .ifu_req_valid(b_ifv), .ifu_req_ready(b_ifr),
      .ifu_rsp_valid(b_irv), .ifu_rsp_inst(b_rinst), .lsu_req_valid(b_lv),
      .lsu_req_ready(b_lr), .lsu_req_wen(b_lw), .lsu_req_size(b_lsz),
      .lsu_rsp_valid(b_lrv), .inst_o(b_inst), .alu_op_o(b_alu), .srca_sel_o(b_sa),
      .srcb_sel_o(b_sb), .imm_type_o(b_imm), .br_taken_i(b_br), .pc_sel_o(b_ps),
      .rd_wen_o(b_rdw), .pc_wen_o(b_pcw), .halt_o(b_halt), .err_o(b_err));

   logic [56:0] a_outs, b_outs;
   assign a_outs = {a_ifv, a_lv, a_lw, a_lsz, a_inst, a_alu, a_sa, a_sb, a_imm, a_ps, a_rdw, a_pcw, a_halt, a_err};
   assign b_outs = {b_ifv, b_lv, b_lw, b_lsz, b_inst, b_alu, b_sa, b_sb, b_imm, b_ps, b_rdw, b_pcw, b_halt, b_err};

   int n_chk = 0, n_fail = 0, cyc = 0;
   exp_t sb[$];
   logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
   logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   logic [2:0] oi_f3 [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_chk++; n_fail++;
      $display("FAIL %s: wait bound expired at cycle %0d", nm, cyc);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic exp_t mk(logic [31:0] inst, logic [4:0] alu, logic [1:0] sa, logic [1:0] sb,
                               logic [2:0] imm, logic [1:0] ps, logic rdw, int ex, logic mem,
                               logic wen, logic [2:0] sz, logic ci);
      exp_t e;
      e.inst = inst; e.alu = alu; e.sa = sa; e.sb = sb; e.imm = imm; e.ps = ps; e.rdw = rdw;
      e.ex = ex; e.mem = mem; e.wen = wen; e.sz = sz; e.ci = ci; e.lrdy = 0;
      return e;
   endfunction

   // Reference model: instruction built from a class and random fields; the
   // expected control outcome follows from the class, not from the bit decode.
   function automatic exp_t gen(int cls, logic br);
      exp_t e;
      logic [4:0] rd = 5'($urandom), rs1 = 5'($urandom), rs2 = 5'($urandom);
      logic [2:0] f3 = 3'($urandom);
      logic alt = 1'b0;
      e = mk(32'd0, 5'd0, 2'd0, 2'd1, 3'd0, 2'd0, rd != 5'd0, 1, 1'b0, 1'b0, 3'd0, 1'b1);
      case (cls)
         0: begin e.inst = {20'($urandom), rd, 7'b0110111}; e.sa = 2'd2; e.imm = 3'd3; end
         1: begin e.inst = {20'($urandom), rd, 7'b0010111}; e.sa = 2'd1; e.imm = 3'd3; end
         2: begin e.inst = {20'($urandom), rd, 7'b1101111}; e.sa = 2'd1; e.sb = 2'd2; e.imm = 3'd4; e.ps = 2'd1; end
         3: begin e.inst = {12'($urandom), rs1, 3'd0, rd, 7'b1100111}; e.sa = 2'd1; e.sb = 2'd2; e.ps = 2'd2; end
         4: begin
            f3 = br_f3[$urandom_range(0, 5)];
            e.inst = {7'($urandom), rs2, rs1, f3, 5'($urandom), 7'b1100011};
            e.alu = 5'b01000; e.sb = 2'd0; e.imm = 3'd2; e.ps = br ? 2'd1 : 2'd0; e.rdw = 1'b0;
         end
         5: begin
            f3 = ld_f3[$urandom_range(0, 4)];
            e.inst = {12'($urandom), rs1, f3, rd, 7'b0000011}; e.mem = 1'b1; e.sz = f3;
         end
         6: begin
            f3 = 3'($urandom_range(0, 2));
            e.inst = {7'($urandom), rs2, rs1, f3, 5'($urandom), 7'b0100011};
            e.imm = 3'd1; e.rdw = 1'b0; e.mem = 1'b1; e.wen = 1'b1; e.sz = f3;
         end
         7: begin
            f3 = oi_f3[$urandom_range(0, 5)];
            e.inst = {12'($urandom), rs1, f3, rd, 7'b0010011}; e.alu = {2'b00, f3};
         end
         8: begin
            f3 = $urandom_range(0, 1) ? 3'd1 : 3'd5;
            alt = (f3 == 3'd5) ? 1'($urandom) : 1'b0;
            e.inst = {1'b0, alt, 5'd0, 5'($urandom), rs1, f3, rd, 7'b0010011};
            e.alu = {1'b0, alt, f3}; e.imm = 3'd5;
         end
         9: begin
            alt = (f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom) : 1'b0;
            e.inst = {1'b0, alt, 5'd0, rs2, rs1, f3, rd, 7'b0110011};
            e.alu = {1'b0, alt, f3}; e.sb = 2'd0; e.ci = 1'b0;
         end
         default: begin
            e.inst = {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
            e.alu = {2'b10, f3}; e.sb = 2'd0; e.ci = 1'b0; e.ex = MLAT;
         end
      endcase
      return e;
   endfunction

   // Drives one instruction through the handshakes; junk responses are
   // offered in cycles where the sequencer must not sample them.
   task automatic issue(input exp_t e, input logic br, input int rdy, input int rspd,
                        input int lrdy, input int lrspd, input logic junk);
      int k;
      e.lrdy = lrdy;
      sb.push_back(e);
      a_br = br;
      k = 0;
      while (a_ifv !== 1'b1 && k < 100) begin tick(); k++; end
      if (k >= 100) begin bound_fail("ifu_req_wait"); return; end
      a_irv = junk; a_rinst = 32'hFFFF_FFFF;
      repeat (rdy) tick();
      a_ifr = 1'b1; tick();
      a_ifr = 1'b0; a_irv = 1'b0;
      repeat (rspd) tick();
      a_irv = 1'b1; a_rinst = e.inst; tick();
      a_irv = 1'b0; a_rinst = 32'hFFFF_FFFF;
      if (e.mem) begin
         k = 0;
         while (a_lv !== 1'b1 && k < 20) begin tick(); k++; end
         if (k >= 20) begin bound_fail("lsu_req_wait"); return; end
         a_lrv = junk;
         repeat (lrdy) tick();
         a_lr = 1'b1; tick();
         a_lr = 1'b0; a_lrv = 1'b0;
         repeat (lrspd) tick();
         a_lrv = 1'b1; tick();
         a_lrv = 1'b0;
      end
      k = 0;
      while (sb.size() != 0 && k < 20) begin tick(); k++; end
      if (k >= 20) bound_fail("wb_wait");
   endtask

   int rsp_cyc = 0, lrsp_cyc = 0, lreq_start = 0, lreq_len = 0;
   exp_t m_e;
   always @(negedge clk) begin
      if (a_rst) lreq_len = 0;
      else begin
         if (a_irv) rsp_cyc = cyc;
         if (a_lrv) lrsp_cyc = cyc;
         if (a_lv) begin
            if (lreq_len == 0) lreq_start = cyc;
            lreq_len++;
            if (sb.size() > 0) begin
               chk("lsu_req_for_mem", sb[0].mem, 1'b1);
               chk("lsu_req_wen", a_lw, sb[0].wen);
               chk("lsu_req_size", a_lsz, sb[0].sz);
            end
         end
         if (a_pcw) begin
            if (sb.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL wb_unexpected: pc_wen_o=1 with no instruction pending (cycle %0d)", cyc);
            end else begin
               m_e = sb.pop_front();
               chk("inst_o", a_inst, m_e.inst);
               chk("rd_wen_o", a_rdw, m_e.rdw);
               chk("pc_sel_o", a_ps, m_e.ps);
               chk("alu_op_o", a_alu, m_e.alu);
               chk("srca_sel_o", a_sa, m_e.sa);
               chk("srcb_sel_o", a_sb, m_e.sb);
               if (m_e.ci) chk("imm_type_o", a_imm, m_e.imm);
               chk("halt_in_wb", a_halt, 1'b0);
               if (m_e.mem) begin
                  chk("lsu_req_start", lreq_start - rsp_cyc, m_e.ex + 1);
                  chk("lsu_req_len", lreq_len, m_e.lrdy + 1);
                  chk("wb_after_lsu_rsp", cyc - lrsp_cyc, 1);
               end else begin
                  chk("wb_latency", cyc - rsp_cyc, m_e.ex + 1);
               end
               lreq_len = 0;
            end
         end
      end
   end

   task automatic b_reset();
      b_rst = 1'b1; tick(); b_rst = 1'b0;
   endtask

   task automatic b_fetch(input logic [31:0] inst);
      int k = 0;
      while (b_ifv !== 1'b1 && k < 20) begin tick(); k++; end
      if (k >= 20) bound_fail("b_ifu_req_wait");
      b_ifr = 1'b1; tick();
      b_ifr = 1'b0; b_irv = 1'b1; b_rinst = inst; tick();
      b_irv = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, t0, cnt;
      exp_t e;
      logic br;
      {a_ifr, a_irv, a_lr, a_lrv, a_br, b_ifr, b_irv, b_lr, b_lrv, b_br} = '0;
      a_rinst = '0; b_rinst = '0;
      a_rst = 1'b1; b_rst = 1'b1;
      repeat (3) tick();
      chk("a_reset_outputs", a_outs, 57'd0);
      chk("b_reset_outputs", b_outs, 57'd0);
      a_rst = 1'b0;
      chk("a_idle_no_fetch", a_ifv, 1'b0);
      tick();
      chk("a_if_after_idle", a_ifv, 1'b1);

      issue(mk(32'h0050_0093, 5'd0, 2'd0, 2'd1, 3'd0, 2'd0, 1'b1, 1, 1'b0, 1'b0, 3'd0, 1'b1), 1'b0, 0, 0, 0, 0, 1'b0);
      issue(mk(32'h0040_A103, 5'd0, 2'd0, 2'd1, 3'd0, 2'd0, 1'b1, 1, 1'b1, 1'b0, 3'b010, 1'b1), 1'b0, 0, 1, 3, 1, 1'b0);
      issue(mk(32'h0220_81B3, 5'b10000, 2'd0, 2'd0, 3'd0, 2'd0, 1'b1, MLAT, 1'b0, 1'b0, 3'd0, 1'b0), 1'b0, 1, 0, 0, 0, 1'b1);
      issue(mk(32'h0020_8463, 5'b01000, 2'd0, 2'd0, 3'd2, 2'd1, 1'b0, 1, 1'b0, 1'b0, 3'd0, 1'b1), 1'b1, 0, 2, 0, 0, 1'b0);
      issue(mk(32'h0020_8463, 5'b01000, 2'd0, 2'd0, 3'd2, 2'd0, 1'b0, 1, 1'b0, 1'b0, 3'd0, 1'b1), 1'b0, 2, 0, 0, 0, 1'b1);

      for (int i = 0; i < 80; i++) begin
         br = 1'($urandom);
         e = gen($urandom_range(0, 10), br);
         issue(e, br, $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), 1'($urandom));
      end
      repeat (4) tick();
      chk("scoreboard_drained", sb.size(), 0);

      // M op with EN_M=0 is illegal; halt is sticky afterwards
      b_rst = 1'b0;
      b_fetch(32'h0220_81B3);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin cnt += b_rdw + b_pcw; tick(); end
      chk("illegal_halt", b_halt, 1'b1);
      chk("illegal_err", b_err, 2'd1);
      chk("illegal_no_wb", cnt, 0);
      b_ifr = 1'b1; b_irv = 1'b1; b_lr = 1'b1; b_lrv = 1'b1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin cnt += b_ifv + b_lv + b_pcw; tick(); end
      {b_ifr, b_irv, b_lr, b_lrv} = '0;
      chk("halt_sticky", {b_halt, b_err}, {1'b1, 2'd1});
      chk("halt_quiet", cnt, 0);

      // IFU timeout
      b_reset();
      k = 0;
      while (b_ifv !== 1'b1 && k < 20) begin tick(); k++; end
      t0 = cyc;
      b_ifr = 1'b1; tick(); b_ifr = 1'b0;
      k = 0;
      while (b_halt !== 1'b1 && k < 40) begin tick(); k++; end
      chk("ifu_timeout_cycles", cyc - t0, 8);
      chk("ifu_timeout_err", b_err, 2'd2);

      // ebreak halts cleanly with no further fetch
      b_reset();
      b_fetch(32'h0010_0073);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin cnt += b_ifv + b_pcw; tick(); end
      chk("ebreak_halt", {b_halt, b_err}, {1'b1, 2'd0});
      chk("ebreak_no_fetch", cnt, 0);

      // LSU timeout
      b_reset();
      b_fetch(32'h0040_A103);
      k = 0;
      while (b_lv !== 1'b1 && k < 20) begin tick(); k++; end
      t0 = cyc;
      k = 0;
      while (b_halt !== 1'b1 && k < 40) begin tick(); k++; end
      chk("lsu_timeout_cycles", cyc - t0, 8);
      chk("lsu_timeout_err", b_err, 2'd3);

      // asynchronous reset while waiting in MW
      b_reset();
      b_fetch(32'h0040_A103);
      k = 0;
      while (b_lv !== 1'b1 && k < 20) begin tick(); k++; end
      b_lr = 1'b1; tick(); b_lr = 1'b0;
      chk("mw_inst_latched", b_inst, 32'h0040_A103);
      b_rst = 1'b1; #1;
      chk("mw_async_reset_outputs", b_outs, 57'd0);
      tick();
      b_rst = 1'b0;
      chk("post_reset_idle", b_ifv, 1'b0);
      tick();
      chk("post_reset_if", b_ifv, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
